totp_timer: RTL and testbench
=============================

Name: totp_timer

Overview:
- Front-end stage directly upstream of the serial HOTP stream block; drives that block's `data`, `key_en` and `msg_en` inputs.
- Keeps a free-running TOTP time-step counter T (seconds divided by STEP_SEC).
- Serialises T LSB-first as the 64-bit message whenever T changes or the host requests it.
- Passes host key loading through on the shared data line and arbitrates it against message sends.

Parameters:
- CLK_HZ, 10000000, clock cycles per second (prescaler terminal count + 1).
- STEP_SEC, 30, seconds per time step.
- MSG_LEN, 64, message / time-step counter width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- host_data  in  1  serial data from host, shared by key bits and time-load bits.
- host_key_en  in  1  host key-loading strobe; passed through to the stream block.
- host_time_en  in  1  host serial time-step load strobe, LSB first.
- host_go  in  1  single-cycle request to recompute with the current T.
- stream_ready  in  1  `ready` level from the stream block.
- data  out  1  serial bit to the stream block.
- key_en  out  1  key strobe to the stream block.
- msg_en  out  1  message strobe to the stream block.
- busy  out  1  high in SEND or WAIT.
- step_tick  out  1  one-cycle pulse when T increments from the prescaler.

Behaviour:
- Reset: all outputs 0; sec_cnt=0, period_cnt=0, T=0, pending=0, load_cnt=0, FSM=IDLE.
- All outputs are registered.
- Prescaler:
  - sec_cnt counts 0..CLK_HZ-1 and wraps.
  - On wrap, period_cnt counts 0..STEP_SEC-1 and wraps.
  - On period wrap: T<=T+1 modulo 2^MSG_LEN, step_tick=1 for that one cycle, pending<=1.
- Time load:
  - While host_time_en=1: shift reg <= {host_data, shift[MSG_LEN-1:1]}; load_cnt saturates at MSG_LEN. The reg keeps the last MSG_LEN bits received.
  - Cycle after host_time_en falls, if load_cnt==MSG_LEN: T<=shift, sec_cnt<=0, period_cnt<=0, pending<=1.
  - Cycle after host_time_en falls, if load_cnt<MSG_LEN: discard the load, no state change.
  - load_cnt<=0 in both cases.
  - A load commit on the same cycle as a prescaler period wrap: the load wins, and step_tick is still pulsed.
- host_go=1 sets pending<=1.
- Key passthrough:
  - When FSM is IDLE or WAIT: key_en<=host_key_en, data<=host_data, one cycle latency.
  - host_key_en rising during SEND aborts SEND that same cycle: msg_en<=0, pending<=1, FSM=IDLE, then passthrough resumes.
  - The stream block pads the truncated message and accepts the later full message.
- FSM:
  - IDLE: if pending && !host_key_en && !host_time_en, snapshot snap<=T, pending<=0, bit_idx<=0, go SEND.
  - SEND: msg_en<=1, data<=snap[bit_idx], bit_idx++. After bit MSG_LEN-1 is driven, msg_en<=0 next cycle and go WAIT.
  - WAIT: wait for a rising edge of stream_ready (0->1 versus the previous cycle), then go IDLE.
  - The stream block drops ready one cycle after msg_en and raises it when the digest is valid.
  - host_key_en in WAIT passes through and does not leave WAIT.
- key_en and msg_en are never both 1 on the same cycle.
- Events arriving during SEND or WAIT only set pending; they are serviced at the next IDLE.
- busy=1 exactly in SEND and WAIT.
- Widths: sec_cnt is $clog2(CLK_HZ) bits; period_cnt is $clog2(STEP_SEC) bits; bit_idx is $clog2(MSG_LEN) bits; load_cnt is $clog2(MSG_LEN)+1 bits.
- Reset mid-SEND: outputs drop to 0 on the next edge, and T and pending are cleared.

Test Plan:
- Prescaler (CLK_HZ=4, STEP_SEC=2, reset released): step_tick at cycles 8, 16, 24, T=1,2,3; first SEND starts the cycle after pending sets, with data bits of 1 LSB-first: 1,0,0,...
- Time load: host_time_en held 64 cycles with value 0x0000000003_5A4E90 LSB-first, then dropped -> T equals that value; msg_en high for exactly 64 cycles; data reproduces the value LSB-first.
- Short load: 40 bits then drop -> T unchanged, no SEND.
- Key abort: host_key_en rises at SEND bit 20 -> msg_en falls the same edge; key bits appear on data/key_en one cycle late; after key_en falls a full 64-bit SEND occurs; key_en and msg_en are never simultaneously 1.
- WAIT handshake: stream_ready model falls 1 cycle after msg_en and rises 2700 cycles later; step_tick during WAIT -> exactly one new SEND after the ready rise, carrying the incremented T.
- Reset asserted mid-SEND -> data, msg_en, key_en and busy are 0 the next cycle, T=0, and no SEND until a new event.

Source files
------------

// File: rtl/totp_timer.sv
// totp_timer: free-running TOTP time-step counter that serialises T LSB-first
// to the HOTP stream block and shares the serial data line with host key loading.
module totp_timer #(
    parameter int unsigned CLK_HZ   = 10000000,
    parameter int unsigned STEP_SEC = 30,
    parameter int unsigned MSG_LEN  = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic host_data,
    input  logic host_key_en,
    input  logic host_time_en,
    input  logic host_go,
    input  logic stream_ready,
    output logic data,
    output logic key_en,
    output logic msg_en,
    output logic busy,
    output logic step_tick
);

    localparam int unsigned SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned PER_W = (STEP_SEC > 1) ? $clog2(STEP_SEC) : 1;
    localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned CNT_W = $clog2(MSG_LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [SEC_W-1:0]     sec_q, sec_d;
    logic [PER_W-1:0]     period_q, period_d;
    logic [MSG_LEN-1:0]   t_q, t_d;
    logic [MSG_LEN-1:0]   shift_q, shift_d;
    logic [MSG_LEN-1:0]   snap_q, snap_d;
    logic [CNT_W-1:0]     load_cnt_q, load_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 pending_q, pending_d;
    logic                 time_en_q, key_prev_q, ready_prev_q;
    logic                 data_q, data_d;
    logic                 key_en_q, key_en_d;
    logic                 msg_en_q, msg_en_d;
    logic                 busy_q, busy_d;
    logic                 tick_q, tick_d;

    logic                 sec_wrap, period_wrap, commit, set_pend, key_rise;

    assign data      = data_q;
    assign key_en    = key_en_q;
    assign msg_en    = msg_en_q;
    assign busy      = busy_q;
    assign step_tick = tick_q;

    // Prescaler, time-step counter and serial time-load path.
    always_comb begin
        sec_wrap    = (sec_q == SEC_W'(CLK_HZ - 1));
        period_wrap = sec_wrap && (period_q == PER_W'(STEP_SEC - 1));
        commit      = time_en_q && !host_time_en && (load_cnt_q == CNT_W'(MSG_LEN));

        sec_d    = sec_wrap ? '0 : sec_q + 1'b1;
        period_d = period_q;
        if (sec_wrap) begin
            period_d = period_wrap ? '0 : period_q + 1'b1;
        end
        t_d    = period_wrap ? t_q + 1'b1 : t_q;
        tick_d = period_wrap;

        // A committed load overrides the increment but the tick still fires.
        if (commit) begin
            t_d      = shift_q;
            sec_d    = '0;
            period_d = '0;
        end

        shift_d    = shift_q;
        load_cnt_d = load_cnt_q;
        if (host_time_en) begin
            shift_d = {host_data, shift_q[MSG_LEN-1:1]};
            if (load_cnt_q != CNT_W'(MSG_LEN)) begin
                load_cnt_d = load_cnt_q + 1'b1;
            end
        end else begin
            load_cnt_d = '0;
        end
    end

    // Send FSM: next state, pending bookkeeping and registered output values.
    always_comb begin
        set_pend  = period_wrap | commit | host_go;
        key_rise  = host_key_en & ~key_prev_q;
        state_d   = state_q;
        snap_d    = snap_q;
        bit_idx_d = bit_idx_q;
        pending_d = pending_q | set_pend;
        data_d    = host_data;
        key_en_d  = host_key_en;
        msg_en_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q && !host_key_en && !host_time_en) begin
                    state_d   = S_SEND;
                    snap_d    = t_q;
                    bit_idx_d = '0;
                    pending_d = set_pend;
                    data_d    = t_q[0];
                    key_en_d  = 1'b0;
                    msg_en_d  = 1'b1;
                end
            end
            S_SEND: begin
                if (key_rise) begin
                    // Key loading pre-empts the message; resend it later from scratch.
                    state_d   = S_IDLE;
                    pending_d = 1'b1;
                end else if (bit_idx_q == IDX_W'(MSG_LEN - 1)) begin
                    state_d  = S_WAIT;
                    data_d   = 1'b0;
                    key_en_d = 1'b0;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    data_d    = snap_q[bit_idx_d];
                    key_en_d  = 1'b0;
                    msg_en_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (stream_ready && !ready_prev_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sec_q        <= '0;
            period_q     <= '0;
            t_q          <= '0;
            shift_q      <= '0;
            snap_q       <= '0;
            load_cnt_q   <= '0;
            bit_idx_q    <= '0;
            pending_q    <= 1'b0;
            time_en_q    <= 1'b0;
            key_prev_q   <= 1'b0;
            ready_prev_q <= 1'b0;
            data_q       <= 1'b0;
            key_en_q     <= 1'b0;
            msg_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            period_q     <= period_d;
            t_q          <= t_d;
            shift_q      <= shift_d;
            snap_q       <= snap_d;
            load_cnt_q   <= load_cnt_d;
            bit_idx_q    <= bit_idx_d;
            pending_q    <= pending_d;
            time_en_q    <= host_time_en;
            key_prev_q   <= host_key_en;
            ready_prev_q <= stream_ready;
            data_q       <= data_d;
            key_en_q     <= key_en_d;
            msg_en_q     <= msg_en_d;
            busy_q       <= busy_d;
            tick_q       <= tick_d;
        end
    end

endmodule

// File: tb/tb_totp_timer.sv
// tb_totp_timer: randomized and directed stimulus for totp_timer, checked every
// cycle against a behavioural model of the time-step / send rules.
module tb_totp_timer;

    localparam int unsigned CLK_HZ   = 4;
    localparam int unsigned STEP_SEC = 2;
    localparam int unsigned MSG_LEN  = 64;
    localparam int          PER      = CLK_HZ * STEP_SEC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_data = 1'b0, host_key_en = 1'b0, host_time_en = 1'b0, host_go = 1'b0;
    logic stream_ready = 1'b1;
    logic data, key_en, msg_en, busy, step_tick;

    int vectors = 0;
    int miscompares = 0;
    int rdy_lat = 5;
    bit rdy_hold = 1'b0;

    totp_timer #(
        .CLK_HZ  (CLK_HZ),
        .STEP_SEC(STEP_SEC),
        .MSG_LEN (MSG_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_data   (host_data),
        .host_key_en (host_key_en),
        .host_time_en(host_time_en),
        .host_go     (host_go),
        .stream_ready(stream_ready),
        .data        (data),
        .key_en      (key_en),
        .msg_en      (msg_en),
        .busy        (busy),
        .step_tick   (step_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_T, m_word;
    int          m_phase;      // cycles elapsed inside the current time step
    bit          m_pend;
    bit          q_bits[$];    // last time-load bits, oldest first
    int          m_mode;       // 0 idle, 1 sending, 2 waiting for ready
    int          m_pos;
    bit          m_pk, m_pt, m_pr;
    logic        e_data, e_key, e_msg, e_busy, e_tick;

    task automatic model_step();
        logic [63:0] t_old, v;
        bit tick, commit, setp;
        if (rst) begin
            m_T = '0; m_word = '0; m_phase = 0; m_pend = 0; q_bits.delete();
            m_mode = 0; m_pos = 0; m_pk = 0; m_pt = 0; m_pr = 0;
            e_data = 0; e_key = 0; e_msg = 0; e_busy = 0; e_tick = 0;
            return;
        end
        t_old  = m_T;
        tick   = (m_phase == PER - 1);
        commit = m_pt && !host_time_en && (q_bits.size() == MSG_LEN);
        m_phase = tick ? 0 : m_phase + 1;
        if (tick) m_T = m_T + 64'd1;
        if (commit) begin
            v = '0;
            for (int i = 0; i < MSG_LEN; i++) v[i] = q_bits[i];
            m_T = v;
            m_phase = 0;
        end
        setp   = tick | host_go | commit;
        e_tick = tick;
        if (host_time_en) begin
            q_bits.push_back(host_data);
            if (q_bits.size() > MSG_LEN) void'(q_bits.pop_front());
        end else begin
            q_bits.delete();
        end

        e_data = host_data; e_key = host_key_en; e_msg = 0;
        if (m_mode == 0) begin
            if (m_pend && !host_key_en && !host_time_en) begin
                m_word = t_old; m_pos = 0; m_mode = 1; m_pend = 0;
                e_data = t_old[0]; e_key = 0; e_msg = 1;
            end
        end else if (m_mode == 1) begin
            if (host_key_en && !m_pk) begin
                m_mode = 0; m_pend = 1;
            end else if (m_pos == MSG_LEN - 1) begin
                m_mode = 2; e_data = 0; e_key = 0;
            end else begin
                m_pos++; e_data = m_word[m_pos]; e_key = 0; e_msg = 1;
            end
        end else begin
            if (stream_ready && !m_pr) m_mode = 0;
        end
        m_pend = m_pend | setp;
        e_busy = (m_mode != 0);
        m_pk = host_key_en; m_pt = host_time_en; m_pr = stream_ready;
    endtask

    // ---------------- observation state ----------------
    int          cyc = 0;
    int          tick_q[$];
    int          run_q[$];
    logic [63:0] sent_q[$];
    logic [63:0] cur_word;
    int          run_len = 0;
    int          first_msg_cyc = 0;

    // Compare process: model advances on each edge, DUT checked 1 time unit later.
    initial begin
        bit was_rst;
        forever begin
            @(posedge clk);
            model_step();
            was_rst = rst;
            #1;
            chk("data", data, e_data);
            chk("key_en", key_en, e_key);
            chk("msg_en", msg_en, e_msg);
            chk("busy", busy, e_busy);
            chk("step_tick", step_tick, e_tick);
            chk("key_msg_excl", key_en & msg_en, 0);
            if (was_rst) begin
                cyc = 0; tick_q.delete(); run_q.delete(); sent_q.delete();
                run_len = 0; first_msg_cyc = 0; cur_word = '0;
            end else begin
                cyc++;
                if (step_tick) tick_q.push_back(cyc);
                if (msg_en) begin
                    if (first_msg_cyc == 0) first_msg_cyc = cyc;
                    if (run_len < MSG_LEN) cur_word[run_len] = data;
                    run_len++;
                end else if (run_len > 0) begin
                    run_q.push_back(run_len);
                    if (run_len == MSG_LEN) sent_q.push_back(cur_word);
                    run_len = 0;
                end
            end
        end
    end

    // Stream block stand-in: ready drops after msg_en, rises rdy_lat cycles later.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stream_ready = 1'b1; cnt = 0;
            end else if (msg_en) begin
                stream_ready = 1'b0; cnt = rdy_lat;
            end else if (cnt > 0) begin
                cnt--;
            end else if (!rdy_hold) begin
                stream_ready = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic drive_load(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            host_time_en = 1'b1;
            host_data    = v[i % 64];
            @(negedge clk);
        end
        host_time_en = 1'b0;
        host_data    = 1'b0;
    endtask

    task automatic wait_run_end(input int budget, input string name);
        int r0;
        bit ok;
        r0 = run_q.size();
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (run_q.size() > r0) begin ok = 1; break; end
        end
        if (!ok) to_fail(name);
    endtask

    task automatic wait_wait_state(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy && !msg_en) begin ok = 1; break; end
        end
        if (!ok) to_fail(name);
    endtask

    task automatic wait_msg_start(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && msg_en; i++) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (msg_en) begin ok = 1; break; end
        end
        if (!ok) to_fail(name);
    endtask

    // Reset, then pin the post-reset timeline with hand-computed values.
    task automatic do_reset_check();
        @(negedge clk);
        rst = 1'b1; host_data = 0; host_key_en = 0; host_time_en = 0; host_go = 0;
        @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_msg_en", msg_en, 0);
        chk("rst_key_en", key_en, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        if (tick_q.size() >= 3) begin
            chk("tick0_cycle", tick_q[0], 8);
            chk("tick1_cycle", tick_q[1], 16);
            chk("tick2_cycle", tick_q[2], 24);
        end else to_fail("tick_count");
        chk("first_send_cycle", first_msg_cyc, 9);
        if (sent_q.size() >= 1) begin
            chk("first_word_lsbs", sent_q[0][2:0], 3'b001);
            chk("first_word", sent_q[0], 64'd1);
        end else to_fail("first_word");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] v;
        int s0, r1, k, n;
        bit kd;

        do_reset_check();

        // Full 64-bit load while held in WAIT, then release ready promptly.
        rdy_hold = 1'b1;
        repeat (3) @(negedge clk);
        wait_wait_state(400, "load_wait_state");
        v  = 64'h0000_0000_035A_4E90;
        s0 = sent_q.size();
        drive_load(v, 64);
        @(negedge clk);
        rdy_hold = 1'b0;
        wait_run_end(200, "load_send");
        chk("load_run_len", run_q[$], 64);
        if (sent_q.size() > s0) chk("load_word", sent_q[s0], v);
        else to_fail("load_word");

        // Short load: discarded, model tracks T and pending.
        rdy_hold = 1'b1;
        repeat (3) @(negedge clk);
        wait_wait_state(400, "short_wait_state");
        drive_load({$urandom, $urandom}, 40);
        repeat (2) @(negedge clk);
        rdy_hold = 1'b0;
        wait_run_end(300, "short_send");

        // Key abort at bit 20 of a message.
        wait_msg_start(400, "abort_msg_start");
        repeat (20) @(negedge clk);
        kd = 1'($urandom_range(0, 1));
        host_key_en = 1'b1; host_data = kd;
        @(negedge clk);
        chk("abort_msg_en", msg_en, 0);
        chk("abort_key_en", key_en, 1);
        chk("abort_data", data, kd);
        chk("abort_run_len", run_q[$], 21);
        repeat (10) begin host_data = 1'($urandom_range(0, 1)); @(negedge clk); end
        host_key_en = 1'b0; host_data = 1'b0;
        wait_run_end(300, "post_abort_send");
        chk("post_abort_run_len", run_q[$], 64);

        // Long WAIT handshake with many ticks pending meanwhile.
        rdy_lat = 2700;
        wait_run_end(400, "long_wait_entry");
        r1 = run_q.size();
        for (int i = 0; i < 3000 && !stream_ready; i++) @(negedge clk);
        chk("wait_quiet_runs", run_q.size() - r1, 0);
        wait_run_end(100, "after_ready_send");
        chk("after_ready_run_len", run_q[$], 64);
        @(negedge clk);
        chk("after_ready_rewait", busy & ~msg_en, 1);
        rdy_lat = 5;

        // Randomized traffic.
        for (int op = 0; op < 150; op++) begin
            k = $urandom_range(0, 11);
            if (k < 4) begin
                n = $urandom_range(1, 30);
                repeat (n) begin host_data = 1'($urandom_range(0, 1)); @(negedge clk); end
            end else if (k < 6) begin
                host_go = 1'b1; @(negedge clk); host_go = 1'b0;
            end else if (k < 8) begin
                n = $urandom_range(1, 15);
                repeat (n) begin
                    host_key_en = 1'b1; host_data = 1'($urandom_range(0, 1)); @(negedge clk);
                end
                host_key_en = 1'b0;
            end else if (k < 10) begin
                drive_load({$urandom, $urandom}, $urandom_range(40, 80));
            end else if (k == 10) begin
                rdy_lat = $urandom_range(1, 40);
                @(negedge clk);
            end else begin
                rst = 1'b1; @(negedge clk); rst = 1'b0;
            end
            host_data = 1'b0;
        end
        rdy_lat = 5;

        // Reset asserted in the middle of a message.
        wait_msg_start(400, "midsend_msg_start");
        repeat (5) @(negedge clk);
        do_reset_check();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
